mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: BUS_TIMEOUT, default 255, number of bus_req cycles without bus_ready before an access is aborted.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: imem_ren in 1; imem_addr in 32. These carry the instruction fetch request.
REQ-005 SHALL have ports: ihit out 1; imem_load out 32. These return the fetch result.
REQ-006 SHALL have ports: dmem_ren in 1; dmem_wen in 1; dmem_addr in 32; dmem_store in 32; dmem_width in 2 (00 byte, 01 half, 10/11 word). These carry the data request.
REQ-007 SHALL have ports: dhit out 1; dmem_load out 32 (right-aligned, zero-filled); dmem_err out 1.
REQ-008 SHALL have port: bus_req out 1  single shared memory port request.
REQ-009 SHALL have ports: bus_wen out 1; bus_addr out 32 (bits[1:0]=00); bus_wdata out 32; bus_be out 4.
REQ-010 SHALL have ports: bus_ready in 1; bus_rdata in 32.

Function
REQ-011 SHALL implement FSM states IDLE, DACC, IACC, and, with MISALIGN_TRAP_EN, DERR.
REQ-012 SHALL, in IDLE, grant data before instruction: (dmem_ren|dmem_wen) -> DACC, else imem_ren -> IACC, else stay IDLE.
REQ-013 SHALL latch address, store data, width and direction at grant; input changes during an access SHALL NOT affect it.
REQ-014 SHALL assert bus_req exactly while in DACC/IACC, driven from registered state.
REQ-015 SHALL treat dmem_ren&dmem_wen as a write.
REQ-016 SHALL, in an access state with bus_ready=1, pulse the matching hit (dhit/ihit) combinationally that cycle; minimum latency is request in cycle N, hit in cycle N+1.
REQ-017 SHALL, on completion, go directly to the next granted state per REQ-012 priority without an IDLE bubble.
REQ-018 SHALL, on completion with the completing request still asserted, not re-grant that same request; it is re-granted only after it is deasserted for at least one cycle.
REQ-019 SHALL drive store bus_wdata as follows: byte = {4{store[7:0]}}; half = {2{store[15:0]}}; word = store.
REQ-020 SHALL drive bus_be as follows: byte = 1<<addr[1:0]; half = addr[1]?1100:0011; word = 1111.
REQ-021 SHALL, on data loads, set dmem_load to bus_rdata shifted right by 8*addr[1:0], masked to 8/16/32 bits; sign extension is not done here.
REQ-022 SHALL set imem_load = bus_rdata, with bus_be=1111 and bus_wen=0 on fetches.
REQ-023 SHALL count bus_req cycles per access, with the counter cleared at grant.
REQ-024 SHALL, when the count reaches BUS_TIMEOUT, drop bus_req next cycle, pulse the hit with dmem_err=1 (data) or imem_load=0 (fetch), and return to IDLE.
REQ-025 SHALL hold hits and dmem_err low when not in the cycle of completion.

Reset
REQ-026 SHALL, while rst is high, immediately force state IDLE and clear the counter.
REQ-027 SHALL, while rst is high, drive bus_req, bus_wen, ihit, dhit and dmem_err to 0 and bus_addr, bus_wdata, bus_be, dmem_load and imem_load to 0.
REQ-028 SHALL, on reset mid-access, drop the access without a hit; bus_req falls asynchronously.

Configuration
REQ-029 SHALL honour macro MISALIGN_TRAP_EN.
REQ-030 SHALL, with MISALIGN_TRAP_EN defined, route a half access with addr[0]=1 or a word access with addr[1:0]!=0 to DERR instead of DACC. DERR issues no bus access and pulses dhit+dmem_err for one cycle, then returns to IDLE.
REQ-031 SHALL, without MISALIGN_TRAP_EN, silently ignore the low address bits (half ignores addr[0], word ignores addr[1:0]); there is no DERR state and dmem_err is asserted only on timeout.

Verification
REQ-032 SHALL cover word fetch: imem_ren=1, addr 0x100, bus_ready=1 in the first bus_req cycle, rdata 0x00000013 -> ihit in cycle 2, imem_load=0x00000013, bus_addr=0x100.
REQ-033 SHALL cover simultaneous requests: dmem_ren and imem_ren both high -> DACC first, then IACC back-to-back, dhit before ihit, no idle cycle between.
REQ-034 SHALL cover byte store: addr 0x203, width 00, store 0xAABBCCDD -> bus_be=1000, bus_wdata=0xDDDDDDDD, bus_wen=1.
REQ-035 SHALL cover half load: addr 0x102, rdata 0x8765_4321 -> dmem_load=0x00008765.
REQ-036 SHALL cover timeout: BUS_TIMEOUT=4 with bus_ready held 0 -> bus_req high 4 cycles, dhit+dmem_err pulse, state IDLE.
REQ-037 SHALL cover reset mid-access: rst asserted during DACC -> bus_req low same cycle, no dhit.
REQ-038 SHALL cover, with MISALIGN_TRAP_EN, a word load at 0x101 -> no bus_req, dhit+dmem_err pulse after 1 cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: instruction/data request ports plus the shared memory bus.
// The master modport is the arbiter's view; slave is the CPU/memory side.
interface mem_arbiter_if;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        ihit;
    logic [31:0] imem_load;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_store;
    logic [1:0]  dmem_width;
    logic        dhit;
    logic [31:0] dmem_load;
    logic        dmem_err;
    logic        bus_req;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    modport master (
        input  imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_store, dmem_width,
        input  bus_ready, bus_rdata,
        output ihit, imem_load, dhit, dmem_load, dmem_err,
        output bus_req, bus_wen, bus_addr, bus_wdata, bus_be
    );
    modport slave (
        output imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_store, dmem_width,
        output bus_ready, bus_rdata,
        input  ihit, imem_load, dhit, dmem_load, dmem_err,
        input  bus_req, bus_wen, bus_addr, bus_wdata, bus_be
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between data and instruction requests, data first.
// Macro MISALIGN_TRAP_EN traps misaligned half/word data accesses in DERR instead of issuing them.
module mem_arbiter #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master arb
);
    localparam int CW = $clog2(BUS_TIMEOUT + 1);
`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, DACC, IACC, DERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;
`endif
    state_t        state;
    logic [CW-1:0] cnt;
    logic          dblk;
    logic          iblk;
    logic [1:0]    a_off;
    logic [1:0]    a_width;
    logic          dreq;
    logic          acc;
    logic          tmo;
    logic          done;
    logic          dcomp;
    logic          icomp;
    logic          free;
    logic          d_go;
    logic          i_go;
    logic          in_derr;
    logic [1:0]    off;
    logic [31:0]   sh;
    logic [31:0]   ld;
    assign dreq = arb.dmem_ren | arb.dmem_wen;
    assign acc = state == DACC || state == IACC;
    assign tmo = acc && !arb.bus_ready && cnt == CW'(BUS_TIMEOUT - 1);
    assign done = acc && (arb.bus_ready || tmo);
`ifdef MISALIGN_TRAP_EN
    logic mis;
    assign in_derr = state == DERR;
    assign mis = (arb.dmem_width == 2'b01 && arb.dmem_addr[0]) ||
                 (arb.dmem_width[1] && arb.dmem_addr[1:0] != 2'b00);
`else
    assign in_derr = 1'b0;
`endif
    assign dcomp = (state == DACC && done) || in_derr;
    assign icomp = state == IACC && done;
    // A timed-out access always falls back to IDLE; a normal completion may chain straight into the next grant.
    assign free = state == IDLE || (done && !tmo);
    assign d_go = dreq && !dblk && !dcomp;
    assign i_go = arb.imem_ren && !iblk && !icomp;
    assign off = arb.dmem_width == 2'b00 ? arb.dmem_addr[1:0] :
                 arb.dmem_width == 2'b01 ? {arb.dmem_addr[1], 1'b0} : 2'b00;
    assign sh = arb.bus_rdata >> {a_off, 3'b000};
    assign ld = a_width == 2'b00 ? {24'b0, sh[7:0]} :
                a_width == 2'b01 ? {16'b0, sh[15:0]} : sh;
    assign arb.bus_req = acc;
    assign arb.dhit = dcomp;
    assign arb.ihit = icomp;
    assign arb.dmem_err = (state == DACC && tmo) || in_derr;
    assign arb.dmem_load = (state == DACC && arb.bus_ready && !arb.bus_wen) ? ld : '0;
    assign arb.imem_load = (state == IACC && arb.bus_ready) ? arb.bus_rdata : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            dblk <= 1'b0;
            iblk <= 1'b0;
            a_off <= 2'b00;
            a_width <= 2'b00;
            arb.bus_wen <= 1'b0;
            arb.bus_addr <= '0;
            arb.bus_wdata <= '0;
            arb.bus_be <= '0;
        end else begin
            // A completed request stays blocked until its requester drops it for a cycle.
            dblk <= dreq && (dblk || dcomp);
            iblk <= arb.imem_ren && (iblk || icomp);
            cnt <= acc ? cnt + 1'b1 : '0;
            if (free && d_go) begin
`ifdef MISALIGN_TRAP_EN
                state <= mis ? DERR : DACC;
`else
                state <= DACC;
`endif
                cnt <= '0;
                a_off <= off;
                a_width <= arb.dmem_width;
                arb.bus_wen <= arb.dmem_wen;
                arb.bus_addr <= arb.dmem_addr & ~32'h3;
                arb.bus_wdata <= arb.dmem_width == 2'b00 ? {4{arb.dmem_store[7:0]}} :
                                 arb.dmem_width == 2'b01 ? {2{arb.dmem_store[15:0]}} : arb.dmem_store;
                arb.bus_be <= arb.dmem_width == 2'b00 ? 4'b0001 << off :
                              arb.dmem_width == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            end else if (free && i_go) begin
                state <= IACC;
                cnt <= '0;
                arb.bus_wen <= 1'b0;
                arb.bus_addr <= arb.imem_addr & ~32'h3;
                arb.bus_wdata <= '0;
                arb.bus_be <= 4'b1111;
            end else if (!acc || done) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter built with BUS_TIMEOUT=4.
// Expected hits are queued when a request is driven and checked when dhit/ihit fires.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    typedef struct packed {
        logic        d;
        logic        err;
        logic        req;
        logic        chk_bus;
        logic        wen;
        logic [31:0] load;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  w;
        logic [31:0] ld;
        logic [3:0]  be;
    } ld_t;
    exp_t sb[$];
    exp_t me;
    logic [31:0] mld;
    mem_arbiter_if bi();
    mem_arbiter #(.BUS_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .arb(bi.master));
    always #5 clk = ~clk;
    function automatic exp_t mk(logic d, logic err, logic req, logic chk, logic wen,
                                logic [31:0] load, logic [31:0] addr, logic [3:0] be, logic [31:0] wdata);
        return {d, err, req, chk, wen, load, addr, be, wdata};
    endfunction
    always @(negedge clk) begin
        if (!rst && (bi.dhit || bi.ihit)) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_hit: dhit=%b ihit=%b, required no hit", bi.dhit, bi.ihit);
            end else begin
                me = sb.pop_front();
                if ({bi.dhit, bi.ihit, bi.dmem_err, bi.bus_req} !== {me.d, !me.d, me.err, me.req}) begin
                    fails++;
                    $display("FAIL sb_flags: dhit/ihit/err/req=%b%b%b%b, required %b%b%b%b",
                             bi.dhit, bi.ihit, bi.dmem_err, bi.bus_req, me.d, !me.d, me.err, me.req);
                end
                if (me.chk_bus) begin
                    tests++;
                    if ({bi.bus_addr, bi.bus_be, bi.bus_wen} !== {me.addr, me.be, me.wen}) begin
                        fails++;
                        $display("FAIL sb_bus: addr=%h be=%b wen=%b, required addr=%h be=%b wen=%b",
                                 bi.bus_addr, bi.bus_be, bi.bus_wen, me.addr, me.be, me.wen);
                    end
                end
                if (me.wen) begin
                    tests++;
                    if (bi.bus_wdata !== me.wdata) begin
                        fails++;
                        $display("FAIL sb_wdata: got %h, required %h", bi.bus_wdata, me.wdata);
                    end
                end else if (!(me.d && me.err)) begin
                    tests++;
                    mld = me.d ? bi.dmem_load : bi.imem_load;
                    if (mld !== me.load) begin
                        fails++;
                        $display("FAIL sb_load: got %h, required %h", mld, me.load);
                    end
                end
            end
        end
    end
    task automatic clear_req();
        bi.imem_ren = 1'b0;
        bi.dmem_ren = 1'b0;
        bi.dmem_wen = 1'b0;
    endtask
    task automatic test_reset();
        bi.imem_ren = 1'b1;
        bi.imem_addr = 32'h40;
        bi.dmem_wen = 1'b1;
        bi.dmem_store = 32'hFFFF_FFFF;
        bi.bus_ready = 1'b1;
        bi.bus_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        tests++;
        if ({bi.bus_req, bi.bus_wen, bi.ihit, bi.dhit, bi.dmem_err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: req/wen/ihit/dhit/err=%b, required 00000",
                     {bi.bus_req, bi.bus_wen, bi.ihit, bi.dhit, bi.dmem_err});
        end
        tests++;
        if ({bi.bus_addr, bi.bus_wdata, bi.bus_be, bi.dmem_load, bi.imem_load} !== 132'b0) begin
            fails++;
            $display("FAIL reset_data: addr=%h wdata=%h be=%b dload=%h iload=%h, required all zero",
                     bi.bus_addr, bi.bus_wdata, bi.bus_be, bi.dmem_load, bi.imem_load);
        end
        @(posedge clk); #1;
        clear_req();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bi.bus_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: bus_req=%b, required 0", bi.bus_req);
        end
    endtask
    task automatic test_fetch();
        @(posedge clk); #1;
        bi.imem_ren = 1'b1;
        bi.imem_addr = 32'h100;
        bi.bus_ready = 1'b1;
        bi.bus_rdata = 32'h13;
        sb.push_back(mk(0, 0, 1, 1, 0, 32'h13, 32'h100, 4'hF, 0));
        @(negedge clk);
        tests++;
        if ({bi.bus_req, bi.ihit} !== 2'b00) begin
            fails++;
            $display("FAIL fetch_c1: req/ihit=%b%b, required 00", bi.bus_req, bi.ihit);
        end
        @(negedge clk);
        tests++;
        if ({bi.bus_req, bi.ihit, bi.imem_load, bi.bus_addr} !== {2'b11, 32'h13, 32'h100}) begin
            fails++;
            $display("FAIL fetch_c2: req=%b ihit=%b load=%h addr=%h, required 1 1 00000013 00000100",
                     bi.bus_req, bi.ihit, bi.imem_load, bi.bus_addr);
        end
        repeat (2) begin
            @(negedge clk);
            tests++;
            if ({bi.bus_req, bi.ihit} !== 2'b00) begin
                fails++;
                $display("FAIL fetch_no_regrant: req/ihit=%b%b, required 00", bi.bus_req, bi.ihit);
            end
        end
        @(posedge clk); #1;
        bi.imem_ren = 1'b0;
        @(posedge clk); #1;
        bi.imem_ren = 1'b1;
        bi.imem_addr = 32'h104;
        bi.bus_rdata = 32'h0050_0093;
        sb.push_back(mk(0, 0, 1, 1, 0, 32'h0050_0093, 32'h104, 4'hF, 0));
        repeat (2) @(negedge clk);
        tests++;
        if (bi.ihit !== 1'b1) begin
            fails++;
            $display("FAIL fetch_regrant: ihit=%b, required 1", bi.ihit);
        end
        @(posedge clk); #1;
        clear_req();
    endtask
    task automatic test_back_to_back();
        @(posedge clk); #1;
        bi.dmem_ren = 1'b1;
        bi.dmem_width = 2'b10;
        bi.dmem_addr = 32'h40;
        bi.imem_ren = 1'b1;
        bi.imem_addr = 32'h80;
        bi.bus_ready = 1'b1;
        bi.bus_rdata = 32'h1122_3344;
        sb.push_back(mk(1, 0, 1, 1, 0, 32'h1122_3344, 32'h40, 4'hF, 0));
        sb.push_back(mk(0, 0, 1, 1, 0, 32'h1122_3344, 32'h80, 4'hF, 0));
        @(negedge clk);
        tests++;
        if ({bi.bus_req, bi.dhit, bi.ihit} !== 3'b000) begin
            fails++;
            $display("FAIL b2b_c1: req/dhit/ihit=%b, required 000", {bi.bus_req, bi.dhit, bi.ihit});
        end
        @(negedge clk);
        tests++;
        if ({bi.bus_req, bi.dhit, bi.ihit} !== 3'b110) begin
            fails++;
            $display("FAIL b2b_data_first: req/dhit/ihit=%b, required 110", {bi.bus_req, bi.dhit, bi.ihit});
        end
        @(negedge clk);
        tests++;
        if ({bi.bus_req, bi.dhit, bi.ihit} !== 3'b101) begin
            fails++;
            $display("FAIL b2b_fetch_next: req/dhit/ihit=%b, required 101", {bi.bus_req, bi.dhit, bi.ihit});
        end
        @(posedge clk); #1;
        clear_req();
        @(negedge clk);
        tests++;
        if (bi.bus_req !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: bus_req=%b, required 0", bi.bus_req);
        end
    endtask
    task automatic test_byte_store();
        @(posedge clk); #1;
        bi.dmem_wen = 1'b1;
        bi.dmem_width = 2'b00;
        bi.dmem_addr = 32'h203;
        bi.dmem_store = 32'hAABB_CCDD;
        bi.bus_ready = 1'b0;
        sb.push_back(mk(1, 0, 1, 1, 1, 32'h0, 32'h200, 4'b1000, 32'hDDDD_DDDD));
        @(posedge clk); #1;
        bi.dmem_addr = 32'h0;
        bi.dmem_store = 32'h1234_5678;
        bi.dmem_width = 2'b10;
        repeat (2) begin
            @(negedge clk);
            tests++;
            if ({bi.bus_req, bi.dhit, bi.bus_wen} !== 3'b101) begin
                fails++;
                $display("FAIL store_wait: req/dhit/wen=%b, required 101", {bi.bus_req, bi.dhit, bi.bus_wen});
            end
        end
        @(posedge clk); #1;
        bi.bus_ready = 1'b1;
        @(negedge clk);
        tests++;
        if ({bi.dhit, bi.bus_be, bi.bus_wdata} !== {1'b1, 4'b1000, 32'hDDDD_DDDD}) begin
            fails++;
            $display("FAIL store_hit: dhit=%b be=%b wdata=%h, required 1 1000 dddddddd",
                     bi.dhit, bi.bus_be, bi.bus_wdata);
        end
        @(posedge clk); #1;
        clear_req();
    endtask
    task automatic test_loads();
        ld_t lt [6];
        lt[0] = {32'h102, 2'b01, 32'h0000_8765, 4'b1100};
        lt[1] = {32'h100, 2'b01, 32'h0000_4321, 4'b0011};
        lt[2] = {32'h101, 2'b00, 32'h0000_0043, 4'b0010};
        lt[3] = {32'h103, 2'b00, 32'h0000_0087, 4'b1000};
        lt[4] = {32'h104, 2'b10, 32'h8765_4321, 4'b1111};
        lt[5] = {32'h108, 2'b11, 32'h8765_4321, 4'b1111};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bi.dmem_ren = 1'b1;
            bi.dmem_addr = lt[i].addr;
            bi.dmem_width = lt[i].w;
            bi.bus_ready = 1'b1;
            bi.bus_rdata = 32'h8765_4321;
            sb.push_back(mk(1, 0, 1, 1, 0, lt[i].ld, lt[i].addr & ~32'h3, lt[i].be, 0));
            repeat (2) @(negedge clk);
            tests++;
            if (bi.dhit !== 1'b1 || bi.dmem_load !== lt[i].ld) begin
                fails++;
                $display("FAIL load_%0d: dhit=%b load=%h, required 1 %h", i, bi.dhit, bi.dmem_load, lt[i].ld);
            end
            @(posedge clk); #1;
            clear_req();
        end
    endtask
    task automatic test_timeout();
        int n;
        int hc;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            bi.bus_ready = 1'b0;
            bi.bus_rdata = 32'hDEAD_BEEF;
            bi.dmem_width = 2'b10;
            bi.dmem_addr = 32'h300;
            bi.imem_addr = 32'h400;
            bi.dmem_ren = (k == 0);
            bi.imem_ren = (k == 1);
            sb.push_back(k == 0 ? mk(1, 1, 1, 1, 0, 0, 32'h300, 4'hF, 0) : mk(0, 0, 1, 1, 0, 0, 32'h400, 4'hF, 0));
            n = 0;
            hc = -1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (bi.bus_req) n++;
                if (bi.dhit || bi.ihit) hc = i;
            end
            tests++;
            if (n !== 4) begin
                fails++;
                $display("FAIL timeout_req_cycles_%0d: got %0d, required 4", k, n);
            end
            tests++;
            if (hc !== 4) begin
                fails++;
                $display("FAIL timeout_hit_cycle_%0d: got %0d, required 4", k, hc);
            end
            @(posedge clk); #1;
            clear_req();
        end
    endtask
    task automatic test_misalign();
        logic [31:0] ma [2];
        logic [1:0]  mw [2];
        ma[0] = 32'h101;
        mw[0] = 2'b10;
        ma[1] = 32'h103;
        mw[1] = 2'b01;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            bi.dmem_ren = 1'b1;
            bi.dmem_addr = ma[i];
            bi.dmem_width = mw[i];
            bi.bus_ready = 1'b1;
            bi.bus_rdata = 32'h5566_7788;
`ifdef MISALIGN_TRAP_EN
            sb.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
            repeat (2) @(negedge clk);
            tests++;
            if ({bi.bus_req, bi.dhit, bi.dmem_err} !== 3'b011) begin
                fails++;
                $display("FAIL misalign_trap_%0d: req/dhit/err=%b, required 011", i, {bi.bus_req, bi.dhit, bi.dmem_err});
            end
            @(negedge clk);
            tests++;
            if ({bi.bus_req, bi.dhit, bi.dmem_err} !== 3'b000) begin
                fails++;
                $display("FAIL misalign_after_%0d: req/dhit/err=%b, required 000", i, {bi.bus_req, bi.dhit, bi.dmem_err});
            end
`else
            sb.push_back(i == 0 ? mk(1, 0, 1, 1, 0, 32'h5566_7788, 32'h100, 4'hF, 0)
                                : mk(1, 0, 1, 1, 0, 32'h0000_5566, 32'h100, 4'b1100, 0));
            repeat (2) @(negedge clk);
            tests++;
            if ({bi.bus_req, bi.dhit, bi.dmem_err} !== 3'b110) begin
                fails++;
                $display("FAIL misalign_ignored_%0d: req/dhit/err=%b, required 110", i, {bi.bus_req, bi.dhit, bi.dmem_err});
            end
`endif
            @(posedge clk); #1;
            clear_req();
        end
    endtask
    task automatic test_reset_mid();
        @(posedge clk); #1;
        bi.dmem_ren = 1'b1;
        bi.dmem_width = 2'b10;
        bi.dmem_addr = 32'h500;
        bi.bus_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (bi.bus_req !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_active: bus_req=%b, required 1", bi.bus_req);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bi.bus_req, bi.dhit, bi.dmem_err} !== 3'b000) begin
            fails++;
            $display("FAIL rst_mid_async: req/dhit/err=%b, required 000", {bi.bus_req, bi.dhit, bi.dmem_err});
        end
        @(posedge clk); #1;
        clear_req();
        @(negedge clk);
        tests++;
        if ({bi.bus_req, bi.dhit, bi.bus_addr} !== {2'b00, 32'h0}) begin
            fails++;
            $display("FAIL rst_mid_hold: req=%b dhit=%b addr=%h, required 0 0 0", bi.bus_req, bi.dhit, bi.bus_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bi.imem_ren = 1'b1;
        bi.imem_addr = 32'h600;
        bi.bus_ready = 1'b1;
        bi.bus_rdata = 32'h77;
        sb.push_back(mk(0, 0, 1, 1, 0, 32'h77, 32'h600, 4'hF, 0));
        repeat (2) @(negedge clk);
        tests++;
        if ({bi.ihit, bi.dhit} !== 2'b10) begin
            fails++;
            $display("FAIL rst_recover: ihit/dhit=%b%b, required 10", bi.ihit, bi.dhit);
        end
        @(posedge clk); #1;
        clear_req();
    endtask
    initial begin
        clear_req();
        bi.imem_addr = '0;
        bi.dmem_addr = '0;
        bi.dmem_store = '0;
        bi.dmem_width = 2'b00;
        bi.bus_ready = 1'b0;
        bi.bus_rdata = '0;
        test_reset();
        test_fetch();
        test_back_to_back();
        test_byte_store();
        test_loads();
        test_timeout();
        test_misalign();
        test_reset_mid();
        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL sb_drain: %0d hits outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
